// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO between the CPU UART_DAT write path and the UART
// emitter. Writes are pushed without per-character polling, the emitter
// drains through a first-word-fall-through valid/ready handshake, and fill
// level plus a sticky overflow flag are exposed for a status read.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_valid,
  input  logic [7:0]    i_wr_data,
  output logic          o_full,
  output logic [AW:0]   o_level,
  output logic          o_ovf,
  input  logic          i_ovf_clr,
  output logic [7:0]    o_tx_data,
  output logic          o_tx_valid,
  input  logic          i_tx_ready,
  output logic          o_busy
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // Storage array; intentionally not reset, contents are qualified by count.
  logic [7:0]    mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          ovf_q,    ovf_d;
  logic          hand_q,   hand_d;

  logic          pop_s;
  logic          push_s;
  logic          drop_s;
  logic          full_s;
  logic          valid_s;

  // Handshake decode: pop frees a slot in the same cycle so a full FIFO can
  // still accept a push when the emitter is draining.
  always_comb begin
    valid_s = (count_q != {(AW+1){1'b0}});
    full_s  = (count_q == FULL_CNT);
    pop_s   = valid_s & i_tx_ready;
    push_s  = i_wr_valid & (~full_s | pop_s);
    drop_s  = i_wr_valid & full_s & ~pop_s;
  end

  // Next-state for pointers, count, overflow flag and hand-off marker.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    hand_d   = pop_s;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // A dropped push wins over a clear in the same cycle.
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (i_ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Control state registers with synchronous active-high reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
      ovf_q    <= 1'b0;
      hand_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      hand_q   <= hand_d;
    end
  end

  // Byte storage write; reset does not clear entries.
  always_ff @(posedge i_clk) begin
    if (push_s && !i_rst) begin
      mem_q[wr_ptr_q] <= i_wr_data;
    end
  end

  // Outputs derived purely from registered state (no input-to-output paths).
  always_comb begin
    o_tx_valid = valid_s;
    o_tx_data  = mem_q[rd_ptr_q];
    o_full     = full_s;
    o_level    = count_q;
    o_ovf      = ovf_q;
    o_busy     = valid_s | hand_q;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo with a queue-based
// reference model checked every cycle plus literal expectations.
module tb_uart_tx_fifo;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_wr_valid = 1'b0;
  logic [7:0] i_wr_data = 8'h00;
  logic       i_ovf_clr = 1'b0;
  logic       i_tx_ready = 1'b0;
  logic       o_full;
  logic [4:0] o_level;
  logic       o_ovf;
  logic [7:0] o_tx_data;
  logic       o_tx_valid;
  logic       o_busy;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_fifo #(.DEPTH(16), .AW(4)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wr_valid (i_wr_valid),
    .i_wr_data  (i_wr_data),
    .o_full     (o_full),
    .o_level    (o_level),
    .o_ovf      (o_ovf),
    .i_ovf_clr  (i_ovf_clr),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain byte queue plus overflow and hand-off flags.
  byte unsigned mq[$];
  bit m_ovf  = 1'b0;
  bit m_hand = 1'b0;
  bit m_on   = 1'b0;

  always @(posedge i_clk) begin
    bit pop_m, drop_m, full_m;
    if (i_rst) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_hand = 1'b0;
      m_on   = 1'b1;
    end else begin
      full_m = (mq.size() == 16);
      pop_m  = (mq.size() != 0) && i_tx_ready;
      drop_m = 1'b0;
      if (pop_m) void'(mq.pop_front());
      if (i_wr_valid) begin
        if (!full_m || pop_m) mq.push_back(i_wr_data);
        else drop_m = 1'b1;
      end
      if (drop_m) m_ovf = 1'b1;
      else if (i_ovf_clr) m_ovf = 1'b0;
      m_hand = pop_m;
    end
  end

  // Per-cycle comparison against the model, sampled away from the active edge.
  always @(negedge i_clk) begin
    if (m_on) begin
      chk("model_valid", int'(o_tx_valid), int'(mq.size() != 0));
      chk("model_level", int'(o_level), mq.size());
      chk("model_full",  int'(o_full), int'(mq.size() == 16));
      chk("model_ovf",   int'(o_ovf), int'(m_ovf));
      chk("model_busy",  int'(o_busy), int'((mq.size() != 0) || m_hand));
      if (mq.size() != 0) chk("model_data", int'(o_tx_data), int'(mq[0]));
    end
  end

  task automatic step(input logic rst, input logic wv, input logic [7:0] d,
                      input logic rdy, input logic clr);
    i_rst      = rst;
    i_wr_valid = wv;
    i_wr_data  = d;
    i_tx_ready = rdy;
    i_ovf_clr  = clr;
    @(negedge i_clk);
  endtask

  initial begin
    int outcnt;
    int pushed;
    logic [7:0] last;
    logic [7:0] expb;

    // Reset state
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst_valid", int'(o_tx_valid), 0);
    chk("rst_level", int'(o_level), 0);
    chk("rst_full",  int'(o_full), 0);
    chk("rst_busy",  int'(o_busy), 0);
    chk("rst_ovf",   int'(o_ovf), 0);

    // Single byte with latency check
    step(1'b0, 1'b1, 8'h41, 1'b1, 1'b0);
    chk("one_valid", int'(o_tx_valid), 1);
    chk("one_data",  int'(o_tx_data), 8'h41);
    chk("one_level", int'(o_level), 1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("one_level_after", int'(o_level), 0);
    chk("one_busy_hand",   int'(o_busy), 1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("one_busy_idle",   int'(o_busy), 0);

    // Fill with ready low, then overflow
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
    chk("fill_full",  int'(o_full), 1);
    chk("fill_level", int'(o_level), 16);
    chk("fill_ovf0",  int'(o_ovf), 0);
    step(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
    chk("drop_ovf",   int'(o_ovf), 1);
    chk("drop_level", int'(o_level), 16);
    for (int i = 0; i < 16; i++) begin
      chk("drain_valid", int'(o_tx_valid), 1);
      chk("drain_data",  int'(o_tx_data), i);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("drain_empty", int'(o_tx_valid), 0);

    // Refill; clear-and-drop collision, then plain clear
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h77, 1'b0, 1'b1);
    chk("clr_drop_ovf", int'(o_ovf), 1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_ovf", int'(o_ovf), 0);

    // Full with simultaneous push and pop
    step(1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
    chk("fullpp_level", int'(o_level), 16);
    chk("fullpp_ovf",   int'(o_ovf), 0);
    last = 8'h00;
    for (int i = 0; i < 16; i++) begin
      expb = (i == 15) ? 8'h55 : 8'(8'h11 + i);
      chk("fullpp_data", int'(o_tx_data), int'(expb));
      last = o_tx_data;
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("fullpp_last",  int'(last), 8'h55);
    chk("fullpp_empty", int'(o_level), 0);

    // Wrap-around with random ready gaps
    outcnt = 0;
    pushed = 0;
    for (int c = 0; c < 400 && outcnt < 40; c++) begin
      logic wv, rdy;
      wv  = (pushed < 40) && (mq.size() < 16) && ($urandom_range(0, 2) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      if (rdy && o_tx_valid) begin
        chk("wrap_order", int'(o_tx_data), 8'h80 + outcnt);
        outcnt++;
      end
      step(1'b0, wv, 8'(8'h80 + pushed), rdy, 1'b0);
      if (wv) pushed++;
    end
    chk("wrap_count", outcnt, 40);
    chk("wrap_ovf",   int'(o_ovf), 0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Reset mid-drain at level 5
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("mid_level", int'(o_level), 5);
    chk("mid_busy",  int'(o_busy), 1);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("mrst_valid", int'(o_tx_valid), 0);
    chk("mrst_level", int'(o_level), 0);
    chk("mrst_ovf",   int'(o_ovf), 0);
    chk("mrst_busy",  int'(o_busy), 0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
